// File: rtl/aes_inv_round.sv
// One registered AES-128 inverse cipher round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.

// Inverse MixColumns on one 32-bit column; byte a0 sits in bits 31:24.
module aes_inv_mixcol (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [0:3][7:0] a, x2, x4, x8, m9, mb, md, me;

    assign a = col_i;

    // 9/b/d/e multiples assembled from the doubling chain x2 -> x4 -> x8
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign x2[i] = xt(a[i]);
        assign x4[i] = xt(x2[i]);
        assign x8[i] = xt(x4[i]);
        assign m9[i] = x8[i] ^ a[i];
        assign mb[i] = x8[i] ^ x2[i] ^ a[i];
        assign md[i] = x8[i] ^ x4[i] ^ a[i];
        assign me[i] = x8[i] ^ x4[i] ^ x2[i];
    end

    assign col_o = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};
endmodule

module aes_inv_round (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic         out_valid,
    output logic [127:0] state_out
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [127:0] v_bus, b_bus, state_d, state_q;
    logic         vld_q;

    // Byte (r,c) lives at bits 127-8*(4c+r); shift-row source column is (c-r) mod 4
    always_comb begin
        v_bus = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                v_bus[127-8*(4*c+r) -: 8] = INV_SBOX[state_in[127-8*(4*((c-r)&3)+r) -: 8]]
                                          ^ round_key[127-8*(4*c+r) -: 8];
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        aes_inv_mixcol u_mix (
            .col_i(v_bus[127-32*c -: 32]),
            .col_o(b_bus[127-32*c -: 32])
        );
    end

    assign state_d = final_round ? v_bus : b_bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) state_q <= state_d;
        end
    end

    assign state_out = state_q;
    assign out_valid = vld_q;
endmodule

// File: tb/tb_aes_inv_round.sv
// Bench for aes_inv_round: FIPS-197 vectors, byte-order and reset cases, then
// random traffic against a table-derived reference round.
module tb_aes_inv_round;
    logic         clk, rst_n, in_valid, final_round, out_valid;
    logic [127:0] state_in, round_key, state_out;

    int total = 0;
    int bad   = 0;

    logic [7:0]   isb [256];
    logic [127:0] exp_state;
    logic         exp_vld;

    localparam logic [127:0] C1_IN   = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] C1_KEY  = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] C1_OUT  = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] C10_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] C10_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C10_OUT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ALL52   = {16{8'h52}};

    aes_inv_round dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .state_in(state_in),
        .round_key(round_key), .final_round(final_round),
        .out_valid(out_valid), .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic f);
        logic [7:0] a [4][4];
        logic [7:0] v [4][4];
        logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [7:0] acc;
        logic [127:0] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) a[r][c] = s[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[r][c] = isb[a[r][(c-r+4)%4]] ^ k[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (f) acc = v[r][c];
                else begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j-r+4)%4], v[j][c]);
                end
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle from a negedge, advance to the next negedge, update the model
    task automatic cyc(input logic v, input logic [127:0] s, input logic [127:0] k, input logic f);
        in_valid = v; state_in = s; round_key = k; final_round = f;
        @(posedge clk);
        @(negedge clk);
        exp_vld = v;
        if (v) exp_state = ref_round(s, k, f);
    endtask

    initial begin
        logic [7:0] inv, b, sb;
        logic [127:0] rs, rk;
        logic rv, rf;

        // inverse S-box derived from GF(2^8) inverses and the forward affine map
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b  = inv;
            sb = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            isb[sb] = 8'(x);
        end

        rst_n = 1'b0; in_valid = 1'b0; final_round = 1'b0; state_in = '0; round_key = '0;
        exp_state = '0; exp_vld = 1'b0;
        #12;
        chk("reset_state", state_out, '0);
        chk("reset_valid", {127'd0, out_valid}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1'b1, C1_IN, C1_KEY, 1'b0);
        chk("inner_kat", state_out, C1_OUT);
        chk("inner_valid", {127'd0, out_valid}, 128'd1);
        cyc(1'b1, C10_IN, C10_KEY, 1'b1);
        chk("final_kat_b2b", state_out, C10_OUT);
        chk("final_valid_b2b", {127'd0, out_valid}, 128'd1);
        cyc(1'b0, '1, '1, 1'b0);
        chk("hold_state", state_out, C10_OUT);
        chk("hold_valid", {127'd0, out_valid}, 128'd0);

        cyc(1'b1, '0, '0, 1'b0);
        chk("zero_inner", state_out, ALL52);
        cyc(1'b1, '0, '0, 1'b1);
        chk("zero_final", state_out, ALL52);
        cyc(1'b1, 128'h00000000_00630000_00000000_00000000, '0, 1'b1);
        chk("byte_order", state_out, 128'h52525252_52525252_52005252_52525252);

        // async reset mid-stream, held across an in_valid edge
        cyc(1'b1, C1_IN, C1_KEY, 1'b0);
        chk("pre_reset", state_out, C1_OUT);
        in_valid = 1'b1; state_in = C10_IN; round_key = C10_KEY; final_round = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", state_out, '0);
        chk("async_rst_valid", {127'd0, out_valid}, 128'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_held_state", state_out, '0);
        chk("rst_held_valid", {127'd0, out_valid}, 128'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        exp_state = '0; exp_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_idle_state", state_out, '0);
        chk("post_rst_idle_valid", {127'd0, out_valid}, 128'd0);
        cyc(1'b1, C10_IN, C10_KEY, 1'b1);
        chk("post_rst_first", state_out, C10_OUT);
        chk("post_rst_valid", {127'd0, out_valid}, 128'd1);

        for (int n = 0; n < 80; n++) begin
            rs = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            rv = ($urandom_range(0, 3) != 0);
            rf = $urandom_range(0, 1) == 1;
            cyc(rv, rs, rk, rf);
            chk("rand_state", state_out, exp_state);
            chk("rand_valid", {127'd0, out_valid}, {127'd0, exp_vld});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
